// File: rtl/gen_col_stream.sv
// gen_col_stream: parallel-to-serial transmitter streaming a two-column complex frame, col0/col1 interleaved.
// Define GEN_COL_STREAM_LSB_FIRST_EN to send each column's LSB slot first (default: MSB slot first).
module gen_col_stream #(
  parameter int SAMPLE_W    = 16,
  parameter int NUM_SAMPLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SAMPLE_W*NUM_SAMPLES-1:0] col0_r,
  input  logic [SAMPLE_W*NUM_SAMPLES-1:0] col0_i,
  input  logic [SAMPLE_W*NUM_SAMPLES-1:0] col1_r,
  input  logic [SAMPLE_W*NUM_SAMPLES-1:0] col1_i,
  input  logic                            out_ready,
  output logic                            sd_valid,
  output logic [SAMPLE_W-1:0]             sdr,
  output logic [SAMPLE_W-1:0]             sdi,
  output logic                            sd_first,
  output logic                            sd_last,
  output logic                            frame_done,
  output logic                            busy
);

  localparam int COL_W     = SAMPLE_W * NUM_SAMPLES;
  localparam int NUM_BEATS = 2 * NUM_SAMPLES;
  localparam int BW        = $clog2(NUM_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

  typedef struct packed {
    logic [COL_W-1:0] c0r;
    logic [COL_W-1:0] c0i;
    logic [COL_W-1:0] c1r;
    logic [COL_W-1:0] c1i;
  } frame_t;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  frame_t           act_frame, pend_frame, in_frame;
  logic             pend_full, pend_full_nxt;
  logic [BW-1:0]    beat, beat_nxt;
  logic             frame_done_nxt;
  logic             take_in, beat_fire, last_fire;
  logic             act_from_in, act_from_pend, pend_from_in;
  logic [COL_W-1:0] col_r, col_i;
  int               slot_idx;

  assign in_frame  = {col0_r, col0_i, col1_r, col1_i};
  assign in_ready  = !pend_full;
  assign take_in   = in_valid && in_ready;
  assign sd_valid  = (state == SEND);
  assign beat_fire = sd_valid && out_ready;
  assign last_fire = beat_fire && (beat == LAST_BEAT);
  assign busy      = sd_valid || pend_full;
  assign sd_first  = sd_valid && (beat == '0);
  assign sd_last   = sd_valid && (beat == LAST_BEAT);

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt      = state;
    pend_full_nxt  = pend_full;
    beat_nxt       = beat;
    frame_done_nxt = 1'b0;
    act_from_in    = 1'b0;
    act_from_pend  = 1'b0;
    pend_from_in   = 1'b0;
    case (state)
      IDLE: begin
        if (take_in) begin
          act_from_in = 1'b1;
          beat_nxt    = '0;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        if (last_fire) begin
          // Chain the next frame with no bubble: pending first, else a same-cycle load.
          frame_done_nxt = 1'b1;
          beat_nxt       = '0;
          if (pend_full) begin
            act_from_pend = 1'b1;
            pend_full_nxt = 1'b0;
          end else if (take_in) begin
            act_from_in = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (beat_fire) beat_nxt = beat + 1'b1;
          if (take_in) begin
            pend_from_in  = 1'b1;
            pend_full_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend_full  <= 1'b0;
      beat       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_full  <= pend_full_nxt;
      beat       <= beat_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // NOTE: frame storage is not reset; every read of it is qualified by state or pend_full.
  always_ff @(posedge clk) begin
    if (act_from_in)        act_frame <= in_frame;
    else if (act_from_pend) act_frame <= pend_frame;
    if (pend_from_in)       pend_frame <= in_frame;
  end

  always_comb begin
    col_r = beat[0] ? act_frame.c1r : act_frame.c0r;
    col_i = beat[0] ? act_frame.c1i : act_frame.c0i;
`ifdef GEN_COL_STREAM_LSB_FIRST_EN
    slot_idx = int'(beat >> 1);
`else
    slot_idx = NUM_SAMPLES - 1 - int'(beat >> 1);
`endif
    sdr = '0;
    sdi = '0;
    if (sd_valid) begin
      for (int s = 0; s < NUM_SAMPLES; s++) begin
        if (s == slot_idx) begin
          sdr = col_r[s*SAMPLE_W +: SAMPLE_W];
          sdi = col_i[s*SAMPLE_W +: SAMPLE_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_gen_col_stream.sv
// tb_gen_col_stream: directed bench for gen_col_stream (default 16-bit samples, 4 per column).
// Expected beat order follows GEN_COL_STREAM_LSB_FIRST_EN when it is defined for the build.
module tb_gen_col_stream;

  localparam int SW = 16;
  localparam int NS = 4;
  localparam int NB = 2 * NS;
  localparam int FW = SW * NS;

  localparam logic [FW-1:0] A0R = 64'h0001_0002_0003_0004;
  localparam logic [FW-1:0] A0I = 64'hA001_A002_A003_A004;
  localparam logic [FW-1:0] A1R = 64'h0011_0012_0013_0014;
  localparam logic [FW-1:0] A1I = 64'hA011_A012_A013_A014;
  localparam logic [FW-1:0] OFS_B = 64'h0100_0100_0100_0100;
  localparam logic [FW-1:0] OFS_C = 64'h0200_0200_0200_0200;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_ready;
  logic [FW-1:0] col0_r, col0_i, col1_r, col1_i;
  logic          sd_valid, sd_first, sd_last, frame_done, busy;
  logic [SW-1:0] sdr, sdi;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] exp_r [NB];
  logic [SW-1:0] exp_i [NB];

  gen_col_stream #(.SAMPLE_W(SW), .NUM_SAMPLES(NS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .col0_r(col0_r), .col0_i(col0_i), .col1_r(col1_r), .col1_i(col1_i),
    .out_ready(out_ready), .sd_valid(sd_valid), .sdr(sdr), .sdi(sdi),
    .sd_first(sd_first), .sd_last(sd_last), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic put_frame(input logic [FW-1:0] ofs);
    col0_r   = A0R + ofs;
    col0_i   = A0I + ofs;
    col1_r   = A1R + ofs;
    col1_i   = A1I + ofs;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    put_frame('0);
    repeat (2) @(negedge clk);
    checks++; if (sd_valid !== 1'b0) begin errors++; $display("FAIL rst_sd_valid got %b want 0", sd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if ({sdr, sdi} !== '0) begin errors++; $display("FAIL rst_data got %h/%h want 0/0", sdr, sdi); end
    checks++; if ({sd_first, sd_last, frame_done} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b want 000", {sd_first, sd_last, frame_done}); end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (sd_valid !== 1'b0) begin errors++; $display("FAIL rst_load_ignored sd_valid got %b want 0", sd_valid); end
  endtask

  // Single frame at full rate, with a collector-style reassembly of the columns.
  task automatic test_basic();
    logic [FW-1:0] rec0r, rec0i, rec1r, rec1i;
    int k, idx;
    rec0r = '0; rec0i = '0; rec1r = '0; rec1i = '0;
    put_frame('0);
    @(negedge clk);
    in_valid = 1'b0;
    col0_r = '1; col0_i = '1; col1_r = '1; col1_i = '1;
    for (int j = 0; j < NB; j++) begin
      checks++; if (sd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid beat %0d got %b want 1", j, sd_valid); end
      checks++; if (sdr !== exp_r[j] || sdi !== exp_i[j]) begin
        errors++; $display("FAIL basic_data beat %0d got %h/%h want %h/%h", j, sdr, sdi, exp_r[j], exp_i[j]); end
      checks++; if (sd_first !== (j == 0) || sd_last !== (j == NB-1) || frame_done !== 1'b0) begin
        errors++; $display("FAIL basic_flags beat %0d got f%b l%b d%b", j, sd_first, sd_last, frame_done); end
      k = j / 2;
`ifdef GEN_COL_STREAM_LSB_FIRST_EN
      idx = k;
`else
      idx = NS - 1 - k;
`endif
      if (j % 2 == 0) begin rec0r[idx*SW +: SW] = sdr; rec0i[idx*SW +: SW] = sdi; end
      else            begin rec1r[idx*SW +: SW] = sdr; rec1i[idx*SW +: SW] = sdi; end
      @(negedge clk);
    end
    checks++; if (frame_done !== 1'b1 || sd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done got d%b v%b b%b want 1 0 0", frame_done, sd_valid, busy); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", frame_done); end
    checks++; if (rec0r !== A0R || rec0i !== A0I || rec1r !== A1R || rec1i !== A1I) begin
      errors++; $display("FAIL loopback got %h %h %h %h", rec0r, rec0i, rec1r, rec1i); end
  endtask

  task automatic test_stall();
    put_frame('0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < NB; j++) begin
      if (j == 2 || j == 5) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++; if (sd_valid !== 1'b1 || sdr !== exp_r[j] || sdi !== exp_i[j] ||
                        sd_first !== 1'b0 || sd_last !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL stall_hold beat %0d got v%b %h/%h d%b", j, sd_valid, sdr, sdi, frame_done); end
        end
        out_ready = 1'b1;
      end
      checks++; if (sdr !== exp_r[j] || sdi !== exp_i[j] || frame_done !== 1'b0) begin
        errors++; $display("FAIL stall_data beat %0d got %h/%h d%b want %h/%h", j, sdr, sdi, frame_done, exp_r[j], exp_i[j]); end
      @(negedge clk);
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", frame_done); end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] want_r, want_i;
    logic          want_rdy;
    put_frame('0);
    @(negedge clk);
    for (int g = 0; g < 2*NB; g++) begin
      if (g == 0) put_frame(OFS_B);
      if (g == 1) put_frame(OFS_C);
      if (g == NB+1) in_valid = 1'b0;
      want_r   = exp_r[g % NB] + ((g >= NB) ? 16'h0100 : 16'h0000);
      want_i   = exp_i[g % NB] + ((g >= NB) ? 16'h0100 : 16'h0000);
      want_rdy = (g == 0 || g == NB);
      checks++; if (sd_valid !== 1'b1 || sdr !== want_r || sdi !== want_i) begin
        errors++; $display("FAIL b2b_data beat %0d got v%b %h/%h want %h/%h", g, sd_valid, sdr, sdi, want_r, want_i); end
      checks++; if (in_ready !== want_rdy || frame_done !== (g == NB) ||
                    sd_first !== (g % NB == 0) || sd_last !== (g % NB == NB-1)) begin
        errors++; $display("FAIL b2b_ctrl beat %0d got r%b d%b f%b l%b", g, in_ready, frame_done, sd_first, sd_last); end
      @(negedge clk);
    end
    want_r = exp_r[0] + 16'h0200;
    checks++; if (sd_valid !== 1'b1 || sd_first !== 1'b1 || sdr !== want_r || frame_done !== 1'b1) begin
      errors++; $display("FAIL b2b_third got v%b f%b %h d%b want 1 1 %h 1", sd_valid, sd_first, sdr, frame_done, want_r); end
    for (int n = 0; n < 40 && busy; n++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    put_frame('0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (sdr !== exp_r[4]) begin errors++; $display("FAIL midrst_pre got %h want %h", sdr, exp_r[4]); end
    rst = 1'b1;
    put_frame(OFS_B);
    @(negedge clk);
    checks++; if (sd_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sdr !== '0) begin
      errors++; $display("FAIL midrst_state got v%b b%b r%b %h", sd_valid, busy, in_ready, sdr); end
    rst = 1'b0;
    put_frame('0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (sd_valid !== 1'b1 || sd_first !== 1'b1 || sdr !== exp_r[0] || sdi !== exp_i[0]) begin
      errors++; $display("FAIL midrst_restart got v%b f%b %h/%h want 1 1 %h/%h", sd_valid, sd_first, sdr, sdi, exp_r[0], exp_i[0]); end
    for (int n = 0; n < 40 && busy; n++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_drain busy got %b want 0", busy); end
  endtask

  initial begin
`ifdef GEN_COL_STREAM_LSB_FIRST_EN
    exp_r = '{16'h0004, 16'h0014, 16'h0003, 16'h0013, 16'h0002, 16'h0012, 16'h0001, 16'h0011};
    exp_i = '{16'hA004, 16'hA014, 16'hA003, 16'hA013, 16'hA002, 16'hA012, 16'hA001, 16'hA011};
`else
    exp_r = '{16'h0001, 16'h0011, 16'h0002, 16'h0012, 16'h0003, 16'h0013, 16'h0004, 16'h0014};
    exp_i = '{16'hA001, 16'hA011, 16'hA002, 16'hA012, 16'hA003, 16'hA013, 16'hA004, 16'hA014};
`endif
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    col0_r = '0; col0_i = '0; col1_r = '0; col1_i = '0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
